instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/instr_decode.sv | 92 +++++++++
 tb/tb_instr_decode.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcodes, decoder state encoding and instruction fields.
// DECODE_HALT_EN adds the HALT state used by the HLT opcode.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned STATE_W = 3;

    // Instruction word field positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OP1_MSB = 11;
    localparam int unsigned OP1_LSB = 9;
    localparam int unsigned OP2_MSB = 8;
    localparam int unsigned OP2_LSB = 6;

    localparam logic [OPC_W-1:0] OP_MOV = 4'b1011;
    localparam logic [OPC_W-1:0] OP_MVI = 4'b1100;
    localparam logic [OPC_W-1:0] OP_LDA = 4'b1101;
    localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

    localparam logic [STATE_W-1:0] S_FETCH     = 3'd0;
    localparam logic [STATE_W-1:0] S_WAIT      = 3'd1;
    localparam logic [STATE_W-1:0] S_IMM_FETCH = 3'd2;
    localparam logic [STATE_W-1:0] S_IMM_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] S_ISSUE     = 3'd4;
`ifdef DECODE_HALT_EN
    localparam logic [STATE_W-1:0] S_HALT      = 3'd5;
`endif

    // Decoded instruction handed to the addressing-mode stage
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [WORD_W-1:0] op1;
        logic [WORD_W-1:0] op2;
        logic [REG_W-1:0]  rf;
    } dec_t;

    function automatic logic is_two_word(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_MVI) || (opcode == OP_LDA);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Instruction fetch/decode front-end: fetches one- or two-word instructions and offers them downstream.
// DECODE_HALT_EN: opcode HLT issues once, then the decoder parks in HALT until redirect or reset.
module instr_decode
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [OPC_W-1:0]  dec_opcode,
    output logic [WORD_W-1:0] dec_op1_regaddr,
    output logic [WORD_W-1:0] dec_op2_regaddr,
    output logic [REG_W-1:0]  rf_rd_addr,
    output logic [ADDR_W-1:0] pc
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    dec_t               dec_q, dec_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dec_q   <= dec_d;
        end
    end

    // Redirect overrides everything; a coincident handshake has already completed on this edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dec_d   = dec_q;
        if (redirect) begin
            state_d = S_FETCH;
            pc_d    = redirect_pc;
        end else begin
            case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    dec_d.opcode = imem_data[OPC_MSB:OPC_LSB];
                    dec_d.op1    = WORD_W'(imem_data[OP1_MSB:OP1_LSB]);
                    dec_d.op2    = WORD_W'(imem_data[OP2_MSB:OP2_LSB]);
                    dec_d.rf     = imem_data[OP2_MSB:OP2_LSB];
                    pc_d         = pc_q + ADDR_W'(1);
                    state_d      = is_two_word(imem_data[OPC_MSB:OPC_LSB]) ? S_IMM_FETCH : S_ISSUE;
                end
                S_IMM_FETCH: state_d = S_IMM_WAIT;
                S_IMM_WAIT: begin
                    dec_d.op2 = imem_data;
                    pc_d      = pc_q + ADDR_W'(1);
                    state_d   = S_ISSUE;
                end
                S_ISSUE: begin
                    if (dec_ready) begin
`ifdef DECODE_HALT_EN
                        state_d = (dec_q.opcode == OP_HLT) ? S_HALT : S_FETCH;
`else
                        state_d = S_FETCH;
`endif
                    end
                end
`ifdef DECODE_HALT_EN
                S_HALT: state_d = S_HALT;
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Strobe is a decode of the state register, held off while reset forces FETCH
    assign imem_rd         = !rst && ((state_q == S_FETCH) || (state_q == S_IMM_FETCH));
    assign imem_addr       = pc_q;
    assign pc              = pc_q;
    assign dec_valid       = (state_q == S_ISSUE);
    assign dec_opcode      = dec_q.opcode;
    assign dec_op1_regaddr = dec_q.op1;
    assign dec_op2_regaddr = dec_q.op2;
    assign rf_rd_addr      = dec_q.rf;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: expected decodes queued with the stimulus, checked on dec_valid.
// Define DECODE_HALT_EN on both bench and RTL to cover the HALT variant.
module tb_instr_decode;

    typedef struct {
        logic [54:0] f;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = '0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_opcode;
    logic [15:0] dec_op1_regaddr;
    logic [15:0] dec_op2_regaddr;
    logic [2:0]  rf_rd_addr;
    logic [15:0] pc;
    logic [54:0] obs;

    logic [15:0] mem [0:65535];
    int          checks   = 0;
    int          errors   = 0;
    int          rd_cnt   = 0;
    int          xfer_cnt = 0;
    exp_t        sb[$];
    exp_t        e;
    int          lat;

    instr_decode #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_opcode     (dec_opcode),
        .dec_op1_regaddr(dec_op1_regaddr),
        .dec_op2_regaddr(dec_op2_regaddr),
        .rf_rd_addr     (rf_rd_addr),
        .pc             (pc)
    );

    assign obs = {dec_opcode, dec_op1_regaddr, dec_op2_regaddr, rf_rd_addr, pc};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns data the cycle after the read strobe; also counts reads and handshakes
    always @(posedge clk) begin
        if (imem_rd) begin
            imem_data <= mem[imem_addr];
            rd_cnt    <= rd_cnt + 1;
        end
        if (dec_valid && dec_ready) xfer_cnt <= xfer_cnt + 1;
    end

    function automatic logic [54:0] mk(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                       input logic [2:0] r, input logic [15:0] p);
        return {o, a, b, r, p};
    endfunction

    task automatic push_exp(input logic [54:0] f, input int l);
        exp_t x;
        x.f   = f;
        x.lat = l;
        sb.push_back(x);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dec_valid && n < 20);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0 || imem_rd !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: dec_valid=%b imem_rd=%b, want 0 0", dec_valid, imem_rd);
        end
        checks++;
        if (obs !== 55'd0) begin
            errors++; $display("FAIL reset_fields: got %h, want 0", obs);
        end
    endtask

    task automatic test_mov();
        clear_mem(); mem[0] = 16'hB280; dec_ready = 1'b1;
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'd1), 2);
        do_reset();
        #1;
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL first_fetch: imem_rd=%b addr=%h, want 1 0000", imem_rd, imem_addr);
        end
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL mov_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL mov_fields: got %h, want %h", obs, e.f); end
    endtask

    task automatic test_mvi();
        clear_mem(); mem[0] = 16'hC200; mem[1] = 16'h1234; dec_ready = 1'b1;
        push_exp(mk(4'hC, 16'd1, 16'h1234, 3'd0, 16'd2), 4);
        do_reset();
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL mvi_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL mvi_fields: got %h, want %h", obs, e.f); end
    endtask

    task automatic test_stall();
        int base_rd;
        int base_x;
        clear_mem(); mem[0] = 16'hB280; dec_ready = 1'b0;
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'd1), 2);
        do_reset();
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL stall_latency: got %0d, want %0d", lat, e.lat); end
        base_rd = rd_cnt; base_x = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (dec_valid !== 1'b1 || imem_rd !== 1'b0 || obs !== e.f) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b rd=%b fields=%h, want 1 0 %h", i, dec_valid, imem_rd, obs, e.f);
            end
        end
        checks++;
        if (rd_cnt !== base_rd) begin errors++; $display("FAIL stall_reads: got %0d reads, want 0", rd_cnt - base_rd); end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        checks++;
        if (xfer_cnt !== base_x + 1) begin
            errors++; $display("FAIL stall_release_xfer: got %0d transfers, want 1", xfer_cnt - base_x);
        end
        checks++;
        if (dec_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 16'h0001) begin
            errors++; $display("FAIL stall_refetch: valid=%b rd=%b addr=%h, want 0 1 0001", dec_valid, imem_rd, imem_addr);
        end
    endtask

    task automatic test_wrap();
        clear_mem(); mem[16'hFFFF] = 16'hD400; mem[0] = 16'hABCD; dec_ready = 1'b1;
        push_exp(mk(4'hD, 16'd2, 16'hABCD, 3'd0, 16'h0001), 2);
        @(negedge clk);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_fetch: rd=%b addr=%h, want 1 ffff", imem_rd, imem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL wrap_imm_fetch: rd=%b addr=%h, want 1 0000", imem_rd, imem_addr);
        end
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL wrap_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL wrap_fields: got %h, want %h", obs, e.f); end
    endtask

    task automatic test_redirect();
        int base_x;
        clear_mem(); mem[0] = 16'hC200; mem[1] = 16'h5555; mem[16'h0040] = 16'hB280; dec_ready = 1'b1;
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'h0041), 2);
        do_reset();
        base_x = xfer_cnt;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0001) begin
            errors++; $display("FAIL redir_imm_fetch: rd=%b addr=%h, want 1 0001", imem_rd, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_rd !== 1'b0 || dec_valid !== 1'b0) begin
            errors++; $display("FAIL redir_imm_wait: rd=%b valid=%b, want 0 0", imem_rd, dec_valid);
        end
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 16'h0040) begin
            errors++; $display("FAIL redir_target: valid=%b rd=%b addr=%h, want 0 1 0040", dec_valid, imem_rd, imem_addr);
        end
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL redir_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL redir_fields: got %h, want %h", obs, e.f); end
        checks++;
        if (xfer_cnt !== base_x) begin
            errors++; $display("FAIL redir_dropped: got %0d transfers, want 0", xfer_cnt - base_x);
        end
    endtask

    task automatic test_reset_mid();
        clear_mem(); mem[0] = 16'hC200; mem[1] = 16'h7777; dec_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        mem[0] = 16'hB280;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || imem_rd !== 1'b0 || obs !== 55'd0) begin
            errors++; $display("FAIL reset_mid_clear: valid=%b rd=%b fields=%h, want 0 0 0", dec_valid, imem_rd, obs);
        end
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'd1), 2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL reset_mid_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL reset_mid_fields: got %h, want %h", obs, e.f); end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[0] = 16'hB280; mem[1] = 16'hC200; mem[2] = 16'h0042; mem[3] = 16'h1E40;
        dec_ready = 1'b1;
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'd1), 2);
        push_exp(mk(4'hC, 16'd1, 16'h0042, 3'd0, 16'd3), 5);
        push_exp(mk(4'h1, 16'd7, 16'd1, 3'd1, 16'd4), 3);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_valid(lat); e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d, want %0d", i, lat, e.lat); end
            checks++;
            if (obs !== e.f) begin errors++; $display("FAIL b2b_fields[%0d]: got %h, want %h", i, obs, e.f); end
        end
    endtask

    task automatic test_halt();
        int base_rd;
        int base_x;
        clear_mem(); mem[0] = 16'hF000; mem[1] = 16'hB280; mem[16'h0010] = 16'hB280; dec_ready = 1'b1;
        push_exp(mk(4'hF, 16'd0, 16'd0, 3'd0, 16'd1), 2);
        do_reset();
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL hlt_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL hlt_fields: got %h, want %h", obs, e.f); end
        base_rd = rd_cnt; base_x = xfer_cnt;
`ifdef DECODE_HALT_EN
        repeat (8) @(negedge clk);
        checks++;
        if (rd_cnt !== base_rd || dec_valid !== 1'b0) begin
            errors++; $display("FAIL halt_parked: reads=%0d valid=%b, want 0 0", rd_cnt - base_rd, dec_valid);
        end
        checks++;
        if (xfer_cnt !== base_x + 1) begin
            errors++; $display("FAIL halt_single_xfer: got %0d transfers, want 1", xfer_cnt - base_x);
        end
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'h0011), 2);
        redirect = 1'b1; redirect_pc = 16'h0010;
        @(negedge clk);
        redirect = 1'b0;
`else
        @(negedge clk);
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0001 || rd_cnt !== base_rd) begin
            errors++; $display("FAIL hlt_plain_fetch: rd=%b addr=%h, want 1 0001", imem_rd, imem_addr);
        end
        push_exp(mk(4'hB, 16'd1, 16'd2, 3'd2, 16'd2), 2);
`endif
        wait_valid(lat); e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL hlt_resume_latency: got %0d, want %0d", lat, e.lat); end
        checks++;
        if (obs !== e.f) begin errors++; $display("FAIL hlt_resume_fields: got %h, want %h", obs, e.f); end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        clear_mem();
        test_reset();
        test_mov();
        test_mvi();
        test_stall();
        test_wrap();
        test_redirect();
        test_reset_mid();
        test_back_to_back();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
